// File: rtl/reg_bank_scheduler.sv
// Shared register bank: self-initialises to entry[i] = i,
// then serves one round-robin-granted access per cycle.
// Ports: i_clk, i_rst_n (async, active-low), i_init_start,
//   i_req/i_we/i_addr/i_wdata (per requester, packed),
//   o_gnt (one-hot, comb), o_rdata/o_rvalid, o_err,
//   o_init_done (high while serving accesses).
module reg_bank_scheduler #(
  parameter  int N_REQ = 2,
  parameter  int DEPTH = 10,
  parameter  int WIDTH = 10,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_init_start,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_we,
  input  logic [N_REQ*AW-1:0]    i_addr,
  input  logic [N_REQ*WIDTH-1:0] i_wdata,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_rvalid,
  output logic                   o_err,
  output logic                   o_init_done
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [PW-1:0]    rr_ptr;
  logic [WIDTH-1:0] bank [DEPTH];

  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    ptr_nxt;
  logic [N_REQ-1:0] gnt;

  logic [AW-1:0]    g_addr;
  logic             g_we;
  logic [WIDTH-1:0] g_wdata;
  logic             addr_ok;
  logic             init_last;

  // Scan from the pointer; the first asserted request wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt     = '0;
    if (state == S_READY && !i_init_start) begin
      for (int o = 0; o < N_REQ; o++) begin
        cand = PW'((int'(rr_ptr) + o) % N_REQ);
        if (!gnt_any && i_req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign o_gnt = gnt;

  always_comb begin
    g_addr  = '0;
    g_we    = 1'b0;
    g_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        g_addr  = i_addr[k*AW +: AW];
        g_we    = i_we[k];
        g_wdata = i_wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  // Extra bit keeps the compare valid when DEPTH is a power of two.
  assign addr_ok = ({1'b0, g_addr} < (AW+1)'(DEPTH));

  assign ptr_nxt = (gnt_idx == PW'(N_REQ-1))
                 ? '0
                 : gnt_idx + 1'b1;

  assign init_last = (idx == AW'(DEPTH-1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_INIT;
      idx         <= '0;
      rr_ptr      <= '0;
      o_rdata     <= '0;
      o_rvalid    <= 1'b0;
      o_err       <= 1'b0;
      o_init_done <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        S_INIT: begin
          if (init_last) begin
            idx         <= '0;
            state       <= S_READY;
            o_init_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_READY: begin
          if (i_init_start) begin
            state       <= S_INIT;
            idx         <= '0;
            o_init_done <= 1'b0;
          end else if (gnt_any) begin
            rr_ptr <= ptr_nxt;
            if (!addr_ok) begin
              o_err <= 1'b1;
              if (!g_we) begin
                o_rdata  <= '0;
                o_rvalid <= 1'b1;
              end
            end else if (!g_we) begin
              o_rdata  <= bank[g_addr];
              o_rvalid <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_INIT;
          idx   <= '0;
        end
      endcase
    end
  end

  // Bank storage carries no reset; INIT defines every entry
  // before any access can be granted.
  always_ff @(posedge i_clk) begin
    if (state == S_INIT) begin
      bank[idx] <= WIDTH'(idx);
    end else if (gnt_any && g_we && addr_ok) begin
      bank[g_addr] <= g_wdata;
    end
  end

endmodule
